// File: rtl/fb_conditioner.sv
// Feedback input conditioner: synchroniser, deglitch filter, rise-to-rise period meter and loss-of-signal detect.
// Optional saturating glitch counter is built only when FB_GLITCH_CNT_EN is defined.
module fb_conditioner #(
   parameter int FILT_LEN     = 4,
   parameter int NOSIG_CYCLES = 5000,
   parameter int PERIOD_MIN   = 125,
   parameter int PERIOD_MAX   = 1000
) (
   input  logic        clk_50,
   input  logic        rst_n,
   input  logic        fb_u,
   output logic        fb,
   output logic        fb_rise,
   output logic [19:0] period,
   output logic        period_valid,
   output logic        range_err,
   output logic        nosig,
   output logic [7:0]  glitch_cnt
);

   localparam int NW = $clog2(NOSIG_CYCLES + 1);
   localparam logic [19:0] PCNT_MAX = '1;

   logic          s0, s1;
   logic [3:0]    filt_cnt;
   logic [19:0]   pcnt;
   logic [19:0]   next_period;
   logic          armed;
   logic [NW-1:0] ncnt;
   logic          filt_hit, toggle, rise_now;

   assign filt_hit    = (filt_cnt + 4'd1) == 4'(FILT_LEN);
   assign toggle      = (s1 != fb) && filt_hit;
   assign rise_now    = toggle && !fb;
   assign nosig       = (ncnt == NW'(NOSIG_CYCLES));
   // Counter restarts one cycle after the rise, so +1 recovers the true edge-to-edge distance.
   assign next_period = (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + 20'd1;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
      end else begin
         s0 <= fb_u;
         s1 <= s0;
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         fb       <= 1'b0;
         filt_cnt <= '0;
         fb_rise  <= 1'b0;
      end else begin
         fb_rise <= rise_now;
         if (s1 != fb) begin
            if (filt_hit) begin
               fb       <= ~fb;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 4'd1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         pcnt         <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         range_err    <= 1'b0;
         armed        <= 1'b0;
      end else begin
         if (fb_rise)
            pcnt <= 20'd1;
         else if (pcnt != PCNT_MAX)
            pcnt <= pcnt + 20'd1;
         period_valid <= rise_now && armed;
         if (rise_now && armed) begin
            period    <= next_period;
            range_err <= (next_period < 20'(PERIOD_MIN)) || (next_period > 20'(PERIOD_MAX));
         end
         if (rise_now)
            armed <= 1'b1;
         else if (nosig)
            armed <= 1'b0;
      end
   end

   // A toggle on the terminal-count cycle still clears, so nosig never glitches high.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n)
         ncnt <= '0;
      else if (toggle)
         ncnt <= '0;
      else if (!nosig)
         ncnt <= ncnt + NW'(1);
   end

`ifdef FB_GLITCH_CNT_EN
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n)
         glitch_cnt <= '0;
      else if ((s1 == fb) && (filt_cnt != 4'd0) && (glitch_cnt != 8'hFF))
         glitch_cnt <= glitch_cnt + 8'd1;
   end
`else
   assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_conditioner.sv
// Directed bench for fb_conditioner: reset, filter latency/glitch, period metering, range, nosig and mid-run reset.
module tb_fb_conditioner;

   logic        clk_50 = 1'b0;
   logic        rst_n;
   logic        fb_u;
   logic        fb, fb_rise, period_valid, range_err, nosig;
   logic [19:0] period;
   logic [7:0]  glitch_cnt;

   int checks = 0;
   int errors = 0;

`ifdef FB_GLITCH_CNT_EN
   localparam logic [7:0] GLITCH_EXP = 8'd1;
`else
   localparam logic [7:0] GLITCH_EXP = 8'd0;
`endif

   fb_conditioner dut (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .fb_u         (fb_u),
      .fb           (fb),
      .fb_rise      (fb_rise),
      .period       (period),
      .period_valid (period_valid),
      .range_err    (range_err),
      .nosig        (nosig),
      .glitch_cnt   (glitch_cnt)
   );

   always #5 clk_50 = ~clk_50;

   task automatic step();
      @(posedge clk_50);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      fb_u  = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();
   endtask

   // One period of p cycles with fb_u high for the first half; reports rises seen in the window.
   task automatic run_period(input int p, output int rises, output logic pv,
                             output logic [19:0] per, output logic re);
      rises = 0; pv = 1'b0; per = '0; re = 1'b0;
      for (int i = 0; i < p; i++) begin
         fb_u = (i < p / 2);
         step();
         if (fb_rise === 1'b1) begin
            rises++;
            pv  = period_valid;
            per = period;
            re  = range_err;
         end
      end
   endtask

   task automatic test_reset();
      int bad_fb;
      bad_fb = 0;
      rst_n = 1'b0;
      fb_u  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         fb_u = ~fb_u;
         step();
         if (fb !== 1'b0) bad_fb++;
      end
      checks++; if (bad_fb !== 0) begin errors++; $display("FAIL reset_fb_held cycles_high=%0d expected=0", bad_fb); end
      checks++; if (fb_rise !== 1'b0) begin errors++; $display("FAIL reset_fb_rise got=%b expected=0", fb_rise); end
      checks++; if (period !== 20'd0) begin errors++; $display("FAIL reset_period got=%0d expected=0", period); end
      checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_period_valid got=%b expected=0", period_valid); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got=%b expected=0", range_err); end
      checks++; if (nosig !== 1'b0) begin errors++; $display("FAIL reset_nosig got=%b expected=0", nosig); end
      checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL reset_glitch_cnt got=%0d expected=0", glitch_cnt); end
      fb_u  = 1'b0;
      rst_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_filter();
      int bad_fb;
      bad_fb = 0;
      for (int k = 0; k < 12; k++) begin
         fb_u = (k < 3);
         step();
         if (fb !== 1'b0) bad_fb++;
      end
      checks++; if (bad_fb !== 0) begin errors++; $display("FAIL glitch3_fb_held cycles_high=%0d expected=0", bad_fb); end
      checks++; if (glitch_cnt !== GLITCH_EXP) begin errors++; $display("FAIL glitch3_count got=%0d expected=%0d", glitch_cnt, GLITCH_EXP); end
      for (int k = 0; k < 12; k++) begin
         fb_u = (k < 4);
         step();
         if (k == 4) begin
            checks++; if (fb !== 1'b0) begin errors++; $display("FAIL pulse4_fb_early got=%b expected=0", fb); end
         end
         if (k == 5) begin
            checks++; if (fb !== 1'b1) begin errors++; $display("FAIL pulse4_fb_toggle got=%b expected=1", fb); end
            checks++; if (fb_rise !== 1'b1) begin errors++; $display("FAIL pulse4_fb_rise got=%b expected=1", fb_rise); end
         end
         if (k == 6) begin
            checks++; if (fb_rise !== 1'b0) begin errors++; $display("FAIL pulse4_rise_width got=%b expected=0", fb_rise); end
         end
      end
      checks++; if (fb !== 1'b0) begin errors++; $display("FAIL pulse4_fb_return got=%b expected=0", fb); end
      checks++; if (glitch_cnt !== GLITCH_EXP) begin errors++; $display("FAIL pulse4_no_glitch got=%0d expected=%0d", glitch_cnt, GLITCH_EXP); end
   endtask

   task automatic test_square();
      int r; logic pv; logic [19:0] per; logic re;
      reset_dut();
      run_period(200, r, pv, per, re);
      checks++; if (r !== 1) begin errors++; $display("FAIL sq_first_rises got=%0d expected=1", r); end
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL sq_first_pv got=%b expected=0", pv); end
      for (int n = 0; n < 3; n++) begin
         run_period(200, r, pv, per, re);
         checks++; if (r !== 1) begin errors++; $display("FAIL sq_rises n=%0d got=%0d expected=1", n, r); end
         checks++; if (pv !== 1'b1) begin errors++; $display("FAIL sq_pv n=%0d got=%b expected=1", n, pv); end
         checks++; if (per !== 20'd200) begin errors++; $display("FAIL sq_period n=%0d got=%0d expected=200", n, per); end
         checks++; if (re !== 1'b0) begin errors++; $display("FAIL sq_range_err n=%0d got=%b expected=0", n, re); end
      end
   endtask

   task automatic test_nosig();
      int r; logic pv; logic [19:0] per; logic re;
      fb_u = 1'b1;
      for (int i = 0; i < 50 && fb !== 1'b1; i++) step();
      checks++; if (fb !== 1'b1) begin errors++; $display("FAIL nosig_wait_fb got=%b expected=1", fb); end
      repeat (4999) step();
      checks++; if (nosig !== 1'b0) begin errors++; $display("FAIL nosig_early got=%b expected=0", nosig); end
      step();
      checks++; if (nosig !== 1'b1) begin errors++; $display("FAIL nosig_assert got=%b expected=1", nosig); end
      fb_u = 1'b0;
      repeat (20) step();
      checks++; if (nosig !== 1'b0) begin errors++; $display("FAIL nosig_clear_on_fall got=%b expected=0", nosig); end
      run_period(300, r, pv, per, re);
      checks++; if (r !== 1) begin errors++; $display("FAIL nosig_rise1_rises got=%0d expected=1", r); end
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL nosig_rise1_pv got=%b expected=0", pv); end
      run_period(300, r, pv, per, re);
      checks++; if (pv !== 1'b1) begin errors++; $display("FAIL nosig_rise2_pv got=%b expected=1", pv); end
      checks++; if (per !== 20'd300) begin errors++; $display("FAIL nosig_rise2_period got=%0d expected=300", per); end
      checks++; if (nosig !== 1'b0) begin errors++; $display("FAIL nosig_rise2_nosig got=%b expected=0", nosig); end
   endtask

   task automatic test_range();
      int r; logic pv; logic [19:0] per; logic re;
      int          lens [7]  = '{1200, 500, 100, 125, 1000, 1001, 200};
      logic [19:0] exp_p[7]  = '{300, 1200, 500, 100, 125, 1000, 1001};
      logic        exp_re[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 7; n++) begin
         run_period(lens[n], r, pv, per, re);
         checks++; if (pv !== 1'b1 || per !== exp_p[n]) begin errors++; $display("FAIL range_period n=%0d got=%0d pv=%b expected=%0d pv=1", n, per, pv, exp_p[n]); end
         checks++; if (re !== exp_re[n]) begin errors++; $display("FAIL range_err n=%0d period=%0d got=%b expected=%b", n, exp_p[n], re, exp_re[n]); end
      end
   endtask

   task automatic test_reset_mid();
      int r; logic pv; logic [19:0] per; logic re;
      fb_u = 1'b1;
      for (int i = 0; i < 50 && fb_rise !== 1'b1; i++) step();
      checks++; if (fb_rise !== 1'b1) begin errors++; $display("FAIL rmid_wait_rise got=%b expected=1", fb_rise); end
      repeat (50) step();
      rst_n = 1'b0;
      #1;
      checks++; if ({fb, fb_rise, period_valid, range_err, nosig} !== 5'b0 || period !== 20'd0 || glitch_cnt !== 8'd0)
         begin errors++; $display("FAIL rmid_outputs got fb=%b rise=%b pv=%b re=%b nosig=%b period=%0d glitch=%0d expected all 0", fb, fb_rise, period_valid, range_err, nosig, period, glitch_cnt); end
      fb_u = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      run_period(200, r, pv, per, re);
      checks++; if (r !== 1) begin errors++; $display("FAIL rmid_rise1_rises got=%0d expected=1", r); end
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL rmid_rise1_pv got=%b expected=0", pv); end
      run_period(200, r, pv, per, re);
      checks++; if (pv !== 1'b1 || per !== 20'd200) begin errors++; $display("FAIL rmid_rise2 got=%0d pv=%b expected=200 pv=1", per, pv); end
   endtask

   initial begin
      rst_n = 1'b0;
      fb_u  = 1'b0;
      test_reset();
      test_filter();
      test_square();
      test_nosig();
      test_range();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_conditioner.md
FB_CONDITIONER -- requirements
Module: fb_conditioner

Interface
REQ-001 Parameter FILT_LEN, default 4: consecutive synced samples that must differ from fb before fb toggles; legal range 1..15.
REQ-002 Parameter NOSIG_CYCLES, default 5000: clk_50 cycles without any fb change before nosig asserts.
REQ-003 Parameter PERIOD_MIN, default 125: lowest in-range period in cycles (400 kHz).
REQ-004 Parameter PERIOD_MAX, default 1000: highest in-range period in cycles (50 kHz).
REQ-005 clk_50  in  1  sole clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 fb_u  in  1  raw asynchronous feedback input.
REQ-008 fb  out  1  synchronised, deglitched feedback level.
REQ-009 fb_rise  out  1  one-cycle pulse on each fb 0->1 transition.
REQ-010 period  out  20  cycles between the last two fb rises.
REQ-011 period_valid  out  1  one-cycle pulse when period updates.
REQ-012 range_err  out  1  last valid period was outside [PERIOD_MIN, PERIOD_MAX].
REQ-013 nosig  out  1  no fb change for NOSIG_CYCLES cycles.
REQ-014 glitch_cnt  out  8  saturating count of rejected pulses.

Function
REQ-015 fb_u SHALL pass through a two-flop synchroniser (s0, s1); no other logic SHALL sample fb_u.
REQ-016 Filter counter SHALL increment on each edge where s1 != fb and clear to 0 on any edge where s1 == fb.
REQ-017 On the edge where the filter counter would reach FILT_LEN, fb SHALL toggle and the counter SHALL clear.
REQ-018 A clean fb_u change captured by s0 at edge N SHALL appear on fb after edge N+1+FILT_LEN.
REQ-019 fb_rise SHALL be registered and high for exactly the one cycle in which fb first reads 1.
REQ-020 The period counter SHALL increment every cycle, saturate at 2^20-1, and restart at 1 on the cycle after each fb rise.
REQ-021 On an fb rise with an armed reference, period SHALL load the counter value plus 1, and period_valid SHALL pulse coincident with fb_rise.
REQ-022 The reference SHALL be armed by any fb rise and disarmed by reset or nosig assertion.
REQ-023 An fb rise while disarmed SHALL pulse fb_rise, leave period unchanged, and not pulse period_valid.
REQ-024 range_err SHALL update only with period_valid: 1 if period < PERIOD_MIN or period > PERIOD_MAX, else 0.
REQ-025 The nosig counter SHALL clear on every fb toggle (either edge) and otherwise count up to NOSIG_CYCLES and hold there.
REQ-026 nosig SHALL be high while the nosig counter equals NOSIG_CYCLES.
REQ-027 If an fb toggle coincides with the nosig terminal count, the toggle SHALL win: counter clears and nosig stays 0.

Reset
REQ-028 While rst_n is low, all outputs and internal state (s0, s1, fb, all counters, reference armed flag) SHALL be 0.
REQ-029 Reset assertion mid-measurement SHALL discard the in-progress period; the first rise after release SHALL not produce period_valid.
REQ-030 Deassertion SHALL be synchronised externally; the block SHALL resume counting on the first edge after release.

Configuration
REQ-031 With FB_GLITCH_CNT_EN defined, glitch_cnt SHALL increment, saturating at 255, on each edge where the filter counter clears from a nonzero value without fb toggling.
REQ-032 Without FB_GLITCH_CNT_EN, glitch_cnt SHALL be tied to 0, no counter logic SHALL be synthesised, and the port SHALL remain.

Verification
REQ-033 Reset held low, fb_u toggling -> fb, fb_rise, period, period_valid, range_err, nosig, glitch_cnt all 0.
REQ-034 Square wave, period 200, defaults -> first rise: fb_rise only; each later rise: period=200, period_valid=1, range_err=0.
REQ-035 3-cycle high pulse on fb_u -> fb stays 0, glitch_cnt=1 (macro on) or 0 (off); 4-cycle pulse -> fb toggles 1 cycle after the 4th synced sample.
REQ-036 fb_u static after a toggle -> nosig=1 exactly 5000 cycles after the fb change; next rise: fb_rise, no period_valid; second rise 300 cycles later: period=300, period_valid=1, nosig=0.
REQ-037 Period 1200 -> period_valid with range_err=1; next period 500 -> range_err=0; period 100 -> range_err=1.
REQ-038 rst_n pulsed low 50 cycles after a rise in a 200-cycle wave -> outputs 0; first rise after release: no period_valid; next rise: period=200.
